// File: rtl/data_mem_uart_dumper_pkg.sv
// Shared types and helpers for the data-memory UART dumper.
// State encoding, byte-per-word math and counter sizing.
package data_mem_uart_dumper_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_SEND   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  function automatic int bytes_per_word(int dw, int bw);
    return (dw + bw - 1) / bw;
  endfunction

  function automatic int byte_cnt_width(int bpw);
    return $clog2(bpw + 1);
  endfunction

endpackage

// File: rtl/data_mem_uart_dumper_if.sv
// Control, data-memory and UART-byte signals of the dumper.
// master = dumper side, slave = surrounding system side.
interface data_mem_uart_dumper_if #(
  parameter int DATA_MEM_WIDTH      = 12,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int BYTE_WIDTH          = 8
) ();

  logic                         startN;
  logic [DATA_MEM_ADDR_WIDTH-1:0] startAddr;
  logic [DATA_MEM_ADDR_WIDTH:0]   wordCount;
  logic [DATA_MEM_WIDTH-1:0]      memData;
  logic [DATA_MEM_ADDR_WIDTH-1:0] memAddr;
  logic [BYTE_WIDTH-1:0]          txByte;
  logic                         txValid;
  logic                         txReady;
  logic                         busy;
  logic                         done;

  modport master (
    input  startN, startAddr, wordCount,
    input  memData, txReady,
    output memAddr, txByte, txValid,
    output busy, done
  );

  modport slave (
    output startN, startAddr, wordCount,
    output memData, txReady,
    input  memAddr, txByte, txValid,
    input  busy, done
  );

endinterface

// File: rtl/data_mem_uart_dumper_serializer.sv
// Splits one memory word into bytes, LSB first,
// and owns the valid/ready handshake toward the UART.
module word_byte_serializer
  import data_mem_uart_dumper_pkg::*;
#(
  parameter int WORD_WIDTH = 12,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  tx_ready,
  output logic [BYTE_WIDTH-1:0] tx_byte,
  output logic                  tx_valid,
  output logic                  last_xfer
);

  localparam int BPW = bytes_per_word(WORD_WIDTH, BYTE_WIDTH);
  localparam int CW  = byte_cnt_width(BPW);
  localparam int SW  = BPW * BYTE_WIDTH;

  logic [SW-1:0] shreg;
  logic [SW-1:0] ext;
  logic [SW-1:0] nxt;
  logic [CW-1:0] byte_cnt;
  logic          xfer;

  assign ext       = SW'(word);
  assign nxt       = shreg >> BYTE_WIDTH;
  assign xfer      = tx_valid & tx_ready;
  assign last_xfer = xfer && (byte_cnt == CW'(BPW - 1));

  // load a word, then advance one byte per accepted transfer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shreg    <= '0;
      byte_cnt <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= ext;
      byte_cnt <= '0;
      tx_byte  <= ext[BYTE_WIDTH-1:0];
      tx_valid <= 1'b1;
    end else if (xfer) begin
      if (last_xfer) begin
        tx_valid <= 1'b0;
      end else begin
        shreg    <= nxt;
        tx_byte  <= nxt[BYTE_WIDTH-1:0];
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_mem_uart_dumper.sv
// Reads a block of DATA_RAM words and streams them
// byte by byte to the UART transmitter.
module data_mem_uart_dumper
  import data_mem_uart_dumper_pkg::*;
#(
  parameter int DATA_MEM_WIDTH      = 12,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int BYTE_WIDTH          = 8
) (
  input logic                    clk,
  input logic                    rstN,
  data_mem_uart_dumper_if.master bus
);

  localparam int AW = DATA_MEM_ADDR_WIDTH;

  state_t                state;
  logic [AW-1:0]         mem_addr;
  logic [AW:0]           remaining;
  logic                  busy;
  logic                  done;
  logic                  load;
  logic                  last_xfer;
  logic [BYTE_WIDTH-1:0] tx_byte;
  logic                  tx_valid;

  assign load        = (state == S_WAIT);
  assign bus.memAddr = mem_addr;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.txByte  = tx_byte;
  assign bus.txValid = tx_valid;

  word_byte_serializer #(
    .WORD_WIDTH (DATA_MEM_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rstN      (rstN),
    .load      (load),
    .word      (bus.memData),
    .tx_ready  (bus.txReady),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .last_xfer (last_xfer)
  );

  // dump sequencing: address, word count and status flags
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_FINISH: begin
          if (!bus.startN) begin
            remaining <= bus.wordCount;
            if (bus.wordCount == '0) begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              mem_addr <= bus.startAddr;
              state    <= S_READ;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: state <= S_SEND;
        S_SEND: begin
          if (last_xfer) begin
            remaining <= remaining - 1'b1;
            if (remaining > (AW+1)'(1)) begin
              mem_addr <= mem_addr + 1'b1;
              state    <= S_READ;
            end else begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_uart_dumper.sv
// Self-checking bench for data_mem_uart_dumper.
// Vector table plus hand sequences, byte scoreboard.
module tb_data_mem_uart_dumper;

  localparam int DW = 12;
  localparam int AW = 12;
  localparam int BW = 8;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] a;
  } exp_t;

  typedef struct {
    int addr;
    int count;
    int rdy_mode;
    int exp_addr;
    int exp_xfers;
  } vec_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  data_mem_uart_dumper_if #(
    .DATA_MEM_WIDTH      (DW),
    .DATA_MEM_ADDR_WIDTH (AW),
    .BYTE_WIDTH          (BW)
  ) bus ();

  data_mem_uart_dumper #(
    .DATA_MEM_WIDTH      (DW),
    .DATA_MEM_ADDR_WIDTH (AW),
    .BYTE_WIDTH          (BW)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.master)
  );

  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) bus.memData <= mem[bus.memAddr];

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad   = 0;
  int xfers = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && bus.txValid && bus.txReady) begin
      xfers++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_byte: got %0h want none", bus.txByte);
      end else begin
        e = sb.pop_front();
        chk("tx_byte", 32'(bus.txByte), 32'(e.b));
        chk("byte_addr", 32'(bus.memAddr), 32'(e.a));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(int addr, int count);
    for (int i = 0; i < count; i++) begin
      int a;
      int w;
      exp_t x;
      a = (addr + i) % 4096;
      w = int'(mem[a]);
      for (int b = 0; b < 2; b++) begin
        x.b = 8'((w >> (8 * b)) & 255);
        x.a = 12'(a);
        sb.push_back(x);
      end
    end
  endtask

  task automatic start(int addr, int count);
    bus.startAddr = 12'(addr);
    bus.wordCount = 13'(count);
    bus.startN    = 1'b0;
    step();
    bus.startN = 1'b1;
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!bus.txValid && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(bus.txValid), 32'd1);
  endtask

  task automatic wait_done(int mode);
    int n = 0;
    while (!bus.done && n < 300) begin
      step();
      if (mode != 0) bus.txReady = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_in_time", 32'(bus.done), 32'd1);
  endtask

  task automatic run_dump(vec_t v);
    xfers = 0;
    push_words(v.addr, v.count);
    bus.txReady = (v.rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    start(v.addr, v.count);
    wait_done(v.rdy_mode);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_mem_addr", 32'(bus.memAddr), 32'(v.exp_addr));
    chk("xfer_count", 32'(xfers), 32'(v.exp_xfers));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[6];
  vec_t v1;

  initial begin
    bus.startN    = 1'b1;
    bus.startAddr = '0;
    bus.wordCount = '0;
    bus.txReady   = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom_range(0, 4095));
    mem[5]    = 12'hABC;
    mem[4094] = 12'h001;
    mem[4095] = 12'h002;
    mem[0]    = 12'h003;

    vecs[0] = '{5, 1, 0, 5, 2};
    vecs[1] = '{4094, 3, 0, 0, 6};
    vecs[2] = '{100, 4, 1, 103, 8};
    vecs[3] = '{4095, 1, 1, 4095, 2};
    vecs[4] = '{0, 0, 0, 4095, 0};
    vecs[5] = '{20, 5, 1, 24, 10};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_addr", 32'(bus.memAddr), 32'd0);
    chk("rst_tx_byte", 32'(bus.txByte), 32'd0);
    chk("rst_tx_valid", 32'(bus.txValid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rstN = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_dump(vecs[i]);

    // exact latency, txReady held high
    xfers = 0;
    push_words(5, 1);
    bus.txReady = 1'b1;
    start(5, 1);
    chk("lat_e0_valid", 32'(bus.txValid), 32'd0);
    chk("lat_e0_busy", 32'(bus.busy), 32'd1);
    step();
    chk("lat_e1_valid", 32'(bus.txValid), 32'd0);
    step();
    chk("lat_e2_valid", 32'(bus.txValid), 32'd1);
    chk("lat_e2_byte", 32'(bus.txByte), 32'hBC);
    step();
    chk("lat_e3_byte", 32'(bus.txByte), 32'h0A);
    step();
    chk("lat_e4_valid", 32'(bus.txValid), 32'd0);
    chk("lat_e4_done", 32'(bus.done), 32'd1);
    chk("lat_mem_addr", 32'(bus.memAddr), 32'd5);
    chk("lat_xfers", 32'(xfers), 32'd2);
    sb.delete();

    // backpressure: byte held for 7 stalled cycles
    xfers = 0;
    push_words(5, 1);
    bus.txReady = 1'b0;
    start(5, 1);
    wait_valid("bp_valid_rise");
    for (int i = 0; i < 7; i++) begin
      chk("bp_hold_byte", 32'(bus.txByte), 32'hBC);
      chk("bp_hold_valid", 32'(bus.txValid), 32'd1);
      step();
    end
    bus.txReady = 1'b1;
    wait_done(0);
    chk("bp_xfers", 32'(xfers), 32'd2);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // start pulse during SEND is ignored
    xfers = 0;
    push_words(10, 2);
    bus.txReady = 1'b1;
    start(10, 2);
    wait_valid("ign_valid_rise");
    bus.startAddr = 12'd200;
    bus.wordCount = 13'd1;
    bus.startN    = 1'b0;
    step();
    bus.startN = 1'b1;
    wait_done(0);
    chk("ign_mem_addr", 32'(bus.memAddr), 32'd11);
    chk("ign_xfers", 32'(xfers), 32'd4);
    chk("ign_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // asynchronous reset in the middle of a word
    push_words(30, 1);
    bus.txReady = 1'b0;
    start(30, 1);
    wait_valid("rmid_valid_rise");
    #1;
    rstN = 1'b0;
    #1;
    chk("rmid_valid", 32'(bus.txValid), 32'd0);
    chk("rmid_busy", 32'(bus.busy), 32'd0);
    chk("rmid_done", 32'(bus.done), 32'd0);
    chk("rmid_mem_addr", 32'(bus.memAddr), 32'd0);
    sb.delete();
    step();
    rstN = 1'b1;
    chk("post_rst_done", 32'(bus.done), 32'd0);

    // wordCount=0 from IDLE: done next cycle, never busy
    bus.txReady = 1'b1;
    start(0, 0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_busy_hold", 32'(bus.busy), 32'd0);
      chk("zero_no_valid", 32'(bus.txValid), 32'd0);
    end

    v1 = '{7, 1, 0, 7, 2};
    run_dump(v1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
